// File: rtl/wb_burst_mux_pkg.sv
// Shared definitions for the Wishbone burst multiplexer: bus widths and the
// transaction-level grant state encoding.
package wb_bus_pkg;

  localparam int WB_DATA_LEN      = 32;
  localparam int VIRTUAL_ADDR_LEN = 32;
  localparam int BL_WIDTH         = 10;

  // IDLE arbitrates; GNTx owns the slave bus for a whole transaction.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

endpackage

// File: rtl/wb_burst_mux_if.sv
// Wishbone bus bundle with burst extensions (burst length and master-ready).
// The master modport drives the request side, the slave modport answers it.
interface wb_burst_mux_if
  import wb_bus_pkg::*;
#(
  parameter int AW  = VIRTUAL_ADDR_LEN,
  parameter int DW  = WB_DATA_LEN,
  parameter int BLW = BL_WIDTH
) ();

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [BLW-1:0]  bl;
  logic            bry;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel, bl, bry,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel, bl, bry,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin picker. The index it presents is only committed
// to last_grant when the owner of the arbiter says a grant is being taken.
module wb_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_idx
);

  logic last_grant;

  // Pick a requester; on a tie favour the one that did not win last time.
  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = last_grant;
    endcase
  end

  // Remember the winner; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance && (|req)) begin
      last_grant <= gnt_idx;
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/wb_burst_mux.sv
// Two-master to one-slave Wishbone arbiter. Grants whole transactions: the
// dcache port (m0) may burst, the uncached port (m1) is single-beat. A beat
// counter detects completion and a watchdog aborts a stalled transaction.
module wb_burst_mux
  import wb_bus_pkg::*;
#(
  parameter int AW      = VIRTUAL_ADDR_LEN,
  parameter int DW      = WB_DATA_LEN,
  parameter int BLW     = BL_WIDTH,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset,
  wb_burst_mux_if.slave  m0,
  wb_burst_mux_if.slave  m1,
  wb_burst_mux_if.master s
);

  // Wide enough to hold TIMEOUT; the watchdog never counts past it.
  localparam int              WDW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WDOG_LIMIT = WDW'(TIMEOUT);

  state_t          state, state_nxt;
  logic [BLW-1:0]  bl_lat, bl_nxt;
  logic [BLW-1:0]  beat_cnt, beat_nxt;
  logic [BLW-1:0]  bl_last;
  logic [WDW-1:0]  wdog, wdog_nxt;
  logic            m0_err_q, m1_err_q;
  logic            m0_err_nxt, m1_err_nxt;
  logic [1:0]      req;
  logic            gnt_idx;
  logic            advance;
  logic            own_cyc;

  logic            bus_cyc, bus_stb, bus_we, bus_bry;
  logic [AW-1:0]   bus_adr;
  logic [DW-1:0]   bus_dat;
  logic [DW/8-1:0] bus_sel;
  logic [BLW-1:0]  bus_bl;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            m0_ack, m1_ack;

  assign req     = {m1.cyc & m1.stb, m0.cyc & m0.stb};
  assign bl_last = bl_lat - BLW'(1);

  wb_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .gnt_idx (gnt_idx)
  );

  // Transaction sequencing: arbitration, beat counting, abort and watchdog.
  always_comb begin
    state_nxt  = state;
    bl_nxt     = bl_lat;
    beat_nxt   = beat_cnt;
    wdog_nxt   = wdog;
    m0_err_nxt = 1'b0;
    m1_err_nxt = 1'b0;
    advance    = 1'b0;
    own_cyc    = 1'b0;
    case (state)
      IDLE: begin
        beat_nxt = {BLW{1'b0}};
        wdog_nxt = {WDW{1'b0}};
        if (|req) begin
          advance = 1'b1;
          if (gnt_idx) begin
            state_nxt = GNT1;
            bl_nxt    = BLW'(1);
          end else begin
            state_nxt = GNT0;
            // A zero burst length means a single beat.
            bl_nxt    = (m0.bl == {BLW{1'b0}}) ? BLW'(1) : m0.bl;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0, GNT1: begin
        own_cyc = (state == GNT0) ? m0.cyc : m1.cyc;
        if (!own_cyc) begin
          // Owner gave up; an ack in this same cycle was still delivered.
          state_nxt = IDLE;
          beat_nxt  = {BLW{1'b0}};
          wdog_nxt  = {WDW{1'b0}};
        end else if (s.ack && (beat_cnt == bl_last)) begin
          // Final beat: the ack takes precedence over a coincident timeout.
          state_nxt = IDLE;
          beat_nxt  = {BLW{1'b0}};
          wdog_nxt  = {WDW{1'b0}};
        end else if (s.ack) begin
          beat_nxt = beat_cnt + BLW'(1);
          wdog_nxt = {WDW{1'b0}};
        end else if ((TIMEOUT != 0) && (wdog == WDOG_LIMIT)) begin
          state_nxt = IDLE;
          beat_nxt  = {BLW{1'b0}};
          wdog_nxt  = {WDW{1'b0}};
          if (state == GNT0) begin
            m0_err_nxt = 1'b1;
          end else begin
            m1_err_nxt = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          wdog_nxt = wdog + WDW'(1);
        end else begin
          wdog_nxt = {WDW{1'b0}};
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = {BLW{1'b0}};
        wdog_nxt  = {WDW{1'b0}};
      end
    endcase
  end

  // State, latched burst length, counters and the one-cycle abort pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bl_lat   <= {BLW{1'b0}};
      beat_cnt <= {BLW{1'b0}};
      wdog     <= {WDW{1'b0}};
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bl_lat   <= bl_nxt;
      beat_cnt <= beat_nxt;
      wdog     <= wdog_nxt;
      m0_err_q <= m0_err_nxt;
      m1_err_q <= m1_err_nxt;
    end
  end

  // Connect the owning master to the slave bus and route the response back.
  always_comb begin
    bus_cyc  = 1'b0;
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_adr  = {AW{1'b0}};
    bus_dat  = {DW{1'b0}};
    bus_sel  = {(DW/8){1'b0}};
    bus_bl   = {BLW{1'b0}};
    bus_bry  = 1'b0;
    m0_rdata = {DW{1'b0}};
    m1_rdata = {DW{1'b0}};
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      GNT0: begin
        bus_cyc  = m0.cyc;
        bus_stb  = m0.stb;
        bus_we   = m0.we;
        bus_adr  = m0.adr;
        bus_dat  = m0.dat_w;
        bus_sel  = m0.sel;
        bus_bl   = bl_lat;
        bus_bry  = m0.bry;
        m0_rdata = s.dat_r;
        m0_ack   = s.ack;
      end
      GNT1: begin
        bus_cyc  = m1.cyc;
        bus_stb  = m1.stb;
        bus_we   = m1.we;
        bus_adr  = m1.adr;
        bus_dat  = m1.dat_w;
        bus_sel  = m1.sel;
        bus_bl   = bl_lat;
        bus_bry  = 1'b1;
        m1_rdata = s.dat_r;
        m1_ack   = s.ack;
      end
      default: begin
        bus_cyc = 1'b0;
      end
    endcase
  end

  assign s.cyc    = bus_cyc;
  assign s.stb    = bus_stb;
  assign s.we     = bus_we;
  assign s.adr    = bus_adr;
  assign s.dat_w  = bus_dat;
  assign s.sel    = bus_sel;
  assign s.bl     = bus_bl;
  assign s.bry    = bus_bry;
  assign m0.dat_r = m0_rdata;
  assign m0.ack   = m0_ack;
  assign m0.err   = m0_err_q;
  assign m1.dat_r = m1_rdata;
  assign m1.ack   = m1_ack;
  assign m1.err   = m1_err_q;

endmodule

// File: tb/tb_wb_burst_mux.sv
// Directed bench for wb_burst_mux: master/slave models driven cycle by cycle,
// expected read beats queued at request time and popped on every master ack.
module tb_wb_burst_mux;

  localparam logic [31:0] A0  = 32'h1000_0A00;
  localparam logic [31:0] A0B = 32'h1000_0C40;
  localparam logic [31:0] A1  = 32'h2000_0B10;

  logic clk;
  logic reset;

  wb_burst_mux_if #(.AW(32), .DW(32), .BLW(10)) m0_bus ();
  wb_burst_mux_if #(.AW(32), .DW(32), .BLW(10)) m1_bus ();
  wb_burst_mux_if #(.AW(32), .DW(32), .BLW(10)) s_bus ();

  wb_burst_mux #(.AW(32), .DW(32), .BLW(10), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] sb[$];
  bit          m0_req, m1_req, m0_hold;
  int          m0_left, m1_left;
  logic [31:0] m0_adr, m1_adr;
  logic [9:0]  m0_bl;
  bit          ack_en, bry_toggle, cyc_prev;
  int          cyc_no, slave_k;
  int          acks0, acks1, err0_cnt, err1_cnt;
  int          first_cyc, err_step, bry_bad, xroute_bad;
  logic        err_cyc;
  logic [9:0]  last_bl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive masters, answer as slave, then sample and score.
  task automatic step();
    logic [32:0] exp_v;
    @(negedge clk);
    cyc_no++;
    m0_bus.cyc   = m0_req;
    m0_bus.stb   = m0_req;
    m0_bus.we    = 1'b0;
    m0_bus.adr   = m0_adr;
    m0_bus.dat_w = ~m0_adr;
    m0_bus.sel   = 4'hF;
    m0_bus.bl    = m0_bl;
    m0_bus.bry   = bry_toggle ? cyc_no[0] : 1'b1;
    m1_bus.cyc   = m1_req;
    m1_bus.stb   = m1_req;
    m1_bus.we    = 1'b0;
    m1_bus.adr   = m1_adr;
    m1_bus.dat_w = ~m1_adr;
    m1_bus.sel   = 4'hF;
    m1_bus.bl    = 10'd0;
    m1_bus.bry   = 1'b0;
    #1;
    if (!s_bus.cyc) slave_k = 0;
    s_bus.ack   = ack_en && s_bus.cyc && s_bus.stb && cyc_prev;
    s_bus.dat_r = s_bus.ack ? {s_bus.adr[15:0], slave_k[15:0]} : 32'h0;
    #1;
    if (m0_bus.ack || m1_bus.ack) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        exp_v = sb.pop_front();
        chk("beat", {m1_bus.ack, (m1_bus.ack ? m1_bus.dat_r : m0_bus.dat_r)}, exp_v);
      end
    end
    if (m0_bus.ack && (m1_bus.ack || m1_bus.dat_r != 32'h0)) xroute_bad++;
    if (m1_bus.ack && (m0_bus.ack || m0_bus.dat_r != 32'h0)) xroute_bad++;
    if (bry_toggle && s_bus.cyc && (s_bus.bry !== m0_bus.bry)) bry_bad++;
    if (s_bus.cyc && !cyc_prev && first_cyc < 0) first_cyc = cyc_no;
    if (s_bus.ack) slave_k++;
    if (m0_bus.ack) begin
      acks0++;
      last_bl = s_bus.bl;
      m0_left--;
      if (m0_left == 0 && !m0_hold) m0_req = 1'b0;
    end
    if (m1_bus.ack) begin
      acks1++;
      m1_left--;
      if (m1_left == 0) m1_req = 1'b0;
    end
    if (m0_bus.err) begin
      err0_cnt++;
      m0_req = 1'b0;
      m0_left = 0;
    end
    if (m1_bus.err) begin
      err1_cnt++;
      if (err_step < 0) begin
        err_step = cyc_no;
        err_cyc  = s_bus.cyc;
      end
      m1_req = 1'b0;
      m1_left = 0;
    end
    cyc_prev = s_bus.cyc;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_left = 0; m1_left = 0; m0_hold = 1'b0;
    sb.delete();
    acks0 = 0; acks1 = 0; err0_cnt = 0; err1_cnt = 0;
    first_cyc = -1; err_step = -1; err_cyc = 1'b0;
    ack_en = 1'b1; bry_toggle = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_m0(input logic [31:0] adr, input logic [9:0] bl, input int beats, input bit hold);
    m0_adr = adr; m0_bl = bl; m0_left = beats; m0_hold = hold; m0_req = 1'b1;
    for (int k = 0; k < beats; k++) sb.push_back({1'b0, adr[15:0], 16'(k)});
  endtask

  task automatic start_m1(input logic [31:0] adr, input int beats);
    m1_adr = adr; m1_left = beats; m1_req = 1'b1;
    for (int k = 0; k < beats; k++) sb.push_back({1'b1, adr[15:0], 16'(k)});
  endtask

  task automatic wait_m0(input string tag, input int budget);
    int n = 0;
    while (m0_left > 0 && n < budget) begin step(); n++; end
    chk(tag, m0_left, 0);
  endtask

  task automatic wait_m1(input string tag, input int budget);
    int n = 0;
    while (m1_left > 0 && n < budget) begin step(); n++; end
    chk(tag, m1_left, 0);
  endtask

  initial begin
    reset = 1'b1;
    m0_adr = A0; m1_adr = A1; m0_bl = 10'd0; last_bl = 10'd0;
    cyc_no = 0; slave_k = 0; cyc_prev = 1'b0; bry_bad = 0; xroute_bad = 0;
    s_bus.ack = 1'b0; s_bus.dat_r = 32'h0; s_bus.err = 1'b0;

    // Reset state
    reset_dut();
    chk("rst_s_ctrl", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.bry}, 4'h0);
    chk("rst_s_adr", s_bus.adr, 32'h0);
    chk("rst_s_bl", s_bus.bl, 10'd0);
    chk("rst_m_resp", {m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}, 4'h0);
    chk("rst_m_dat", {m0_bus.dat_r, m1_bus.dat_r}, 64'h0);

    // m0 alone, bl=4
    start_m0(A0, 10'd4, 4, 1'b1);
    step();
    chk("t1_arb_latency", s_bus.cyc, 1'b0);
    step();
    chk("t1_granted", s_bus.cyc, 1'b1);
    chk("t1_bl", s_bus.bl, 10'd4);
    wait_m0("t1_done", 20);
    step();
    chk("t1_dead_cycle", s_bus.cyc, 1'b0);
    chk("t1_m1_ack", acks1, 0);
    chk("t1_acks", acks0, 4);
    m0_req = 1'b0;
    step();

    // Simultaneous requests after reset, then a repeat tie
    reset_dut();
    start_m0(A0, 10'd2, 2, 1'b0);
    start_m1(A1, 1);
    step();
    step();
    chk("t2_first_owner", s_bus.adr, A0);
    wait_m0("t2_m0_done", 20);
    wait_m1("t2_m1_done", 20);
    start_m0(A0B, 10'd1, 1, 1'b0);
    start_m1(A1, 1);
    step();
    step();
    chk("t2_repeat_owner", s_bus.adr, A0B);
    wait_m0("t2_m0b_done", 20);
    wait_m1("t2_m1b_done", 20);
    chk("t2_sb_empty", sb.size(), 0);

    // m0 bl=8 aborted after 3 beats with m1 pending
    reset_dut();
    start_m0(A0, 10'd8, 3, 1'b0);
    step();
    step();
    start_m1(A1, 1);
    wait_m0("t3_m0_beats", 20);
    step();
    chk("t3_drop_cycle", s_bus.cyc, 1'b0);
    step();
    chk("t3_idle_cycle", s_bus.cyc, 1'b0);
    step();
    chk("t3_m1_grant", {s_bus.cyc, s_bus.adr}, {1'b1, A1});
    wait_m1("t3_m1_done", 20);
    chk("t3_no_err", err0_cnt, 0);

    // Watchdog: slave never acks m1
    reset_dut();
    ack_en = 1'b0;
    start_m1(A1, 1);
    sb.delete();
    for (int i = 0; i < 40; i++) step();
    chk("t4_err_count", err1_cnt, 1);
    chk("t4_err_delay", err_step - first_cyc, 17);
    chk("t4_err_cyc", err_cyc, 1'b0);
    chk("t4_m0_err", err0_cnt, 0);
    ack_en = 1'b1;

    // Reset in the middle of a 4-beat burst
    reset_dut();
    start_m0(A0, 10'd4, 4, 1'b0);
    for (int i = 0; i < 20 && m0_left > 2; i++) step();
    chk("t5_two_beats", m0_left, 2);
    reset = 1'b1;
    step();
    chk("t5_rst_ctrl", {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.bry, m0_bus.ack, m0_bus.err, m1_bus.ack, s_bus.bl}, 17'h0);
    chk("t5_rst_adr", s_bus.adr, 32'h0);
    chk("t5_rst_dat", m0_bus.dat_r, 32'h0);
    m0_req = 1'b0; m0_left = 0; sb.delete();
    reset = 1'b0;
    step();
    step();
    step();
    acks0 = 0;
    start_m0(A0B, 10'd4, 4, 1'b1);
    wait_m0("t5_new_burst", 20);
    step();
    chk("t5_dead_cycle", s_bus.cyc, 1'b0);
    chk("t5_fresh_acks", acks0, 4);
    chk("t5_no_err", err0_cnt, 0);
    m0_req = 1'b0;
    step();

    // Burst length 0 and the maximum length with bry toggling
    reset_dut();
    start_m0(A0, 10'd0, 1, 1'b1);
    wait_m0("t6_bl0_done", 10);
    step();
    chk("t6_bl0_complete", s_bus.cyc, 1'b0);
    chk("t6_bl0_len", last_bl, 10'd1);
    m0_req = 1'b0;
    step();
    step();
    acks0 = 0;
    bry_toggle = 1'b1;
    start_m0(A0B, 10'd1023, 1023, 1'b1);
    wait_m0("t6_bl1023_done", 1200);
    step();
    chk("t6_bl1023_complete", s_bus.cyc, 1'b0);
    chk("t6_bl1023_acks", acks0, 1023);
    chk("t6_bl1023_len", last_bl, 10'd1023);
    chk("t6_bry_mirror", bry_bad, 0);
    m0_req = 1'b0;
    bry_toggle = 1'b0;
    step();
    step();

    chk("sb_drained", sb.size(), 0);
    chk("cross_routing", xroute_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_mux.md
Name: wb_burst_mux

Overview:
- Two-master to one-slave Wishbone arbiter with burst support. It sits between the L1 dcache refill/writeback port (master 0, burst-capable) and the core's uncached "others" port (master 1, single-beat).
- Drives the SoC data-bus port: cpu2dmux adr/dat/sel/we/cyc/stb/bl/bry.
- Grants whole transactions, not single beats: round-robin, a burst counter, and an ack watchdog.

Parameters:
- AW, 32, address width
- DW, 32, data width; sel width = DW/8
- BLW, 10, burst-length field width
- TIMEOUT, 1023, cycles without ack before a granted transaction is aborted; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  dcache strobes
- m0_adr_i  in  AW  dcache address
- m0_dat_i  in  DW  dcache write data
- m0_sel_i  in  DW/8  dcache byte select
- m0_bl_i  in  BLW  dcache burst length in beats
- m0_bry_i  in  1  dcache ready for next beat
- m0_dat_o  out  DW  read data to dcache
- m0_ack_o  out  1  beat ack to dcache
- m0_err_o  out  1  watchdog abort pulse to dcache
- m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i  in  as m0  others-port request
- m1_dat_o, m1_ack_o, m1_err_o  out  DW/1/1  others-port response
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SoC data bus
- s_adr_o  out  AW
- s_dat_o  out  DW
- s_sel_o  out  DW/8
- s_bl_o  out  BLW
- s_bry_o  out  1
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave beat ack

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, last_grant=1 (so m0 wins the first tie), beat_cnt=0, wdog=0. All s_* outputs 0; all m*_ack_o, m*_err_o, m*_dat_o 0.
- FSM states: IDLE, GNT0, GNT1.
- IDLE transitions:
  - A master requests when cyc&stb.
  - Only one requests -> grant it.
  - Both request -> grant the one not equal to last_grant.
  - The grant is registered: s_* become valid the cycle after the request is seen (1-cycle arbitration latency). last_grant updates on entry.
- Grant entry:
  - m0: latch bl_lat = (m0_bl_i==0) ? 1 : m0_bl_i.
  - m1: bl_lat = 1.
- In GNTx:
  - s_cyc/stb/we/adr/dat/sel are combinationally muxed from master x.
  - s_bl_o = bl_lat. s_bry_o = m0_bry_i in GNT0, 1 in GNT1.
  - s_ack_i and s_dat_i route only to master x. The other master sees ack=0, dat=0.
- beat_cnt:
  - Increments on each s_ack_i while granted.
  - Ack with beat_cnt==bl_lat-1 -> transaction complete: go to IDLE, beat_cnt=0.
  - The cycle after completion always passes through IDLE (one dead cycle), which guarantees rearbitration.
- Abort:
  - Granted master drops cyc before completion -> IDLE next cycle, beat_cnt=0, no err.
  - A late s_ack_i arriving in IDLE is dropped.
- Watchdog:
  - wdog counts cycles in GNTx with no ack and resets on every ack.
  - wdog==TIMEOUT -> m_err_o pulses 1 cycle to master x, state goes to IDLE, s_cyc drops.
- Simultaneous events:
  - Ack and cyc-drop in the same cycle -> the ack is delivered; state goes to IDLE.
  - Final ack and timeout in the same cycle -> ack wins, no err.
- Reset mid-burst: the next cycle is IDLE with all outputs 0; no ack or err is emitted.
- bl=1 on m0 behaves identically to a single-beat m1 access.

Decomposition:
- Shared package wb_bus_pkg:
  - state enum {IDLE, GNT0, GNT1}
  - WB_DATA_LEN, VIRTUAL_ADDR_LEN, BL_WIDTH constants
- Natural sub-module: wb_rr_arb2. It is the two-request round-robin picker holding last_grant, with inputs req[1:0] and advance, and output gnt_idx.
- The beat counter and watchdog stay in the top block.

Test Plan:
- m0 only, bl=4, slave acks every cycle from the cycle after s_cyc:
  - 4 acks reach m0; s_bl_o=4.
  - s_cyc drops after the 4th ack; IDLE for 1 cycle; m1_ack_o stays 0 throughout.
- m0 and m1 request in the same cycle after reset:
  - m0 granted first (bl=2); after 2 acks, m1 granted.
  - A repeat simultaneous request then grants m0 (round-robin).
- m0 bl=8, m0 drops cyc after 3 acks:
  - State reaches IDLE next cycle; no err.
  - A pending m1 is granted within 2 cycles.
- TIMEOUT=16, m1 read, slave never acks:
  - m1_err_o pulses exactly once, 17 cycles after grant; s_cyc_o goes to 0.
- Reset asserted mid-burst (beat 2 of 4):
  - Next cycle all outputs are 0.
  - After release, a new m0 bl=4 burst completes with a fresh count of 4 acks.
- m0 bl=0, and bl=1023 with m0_bry_i toggling:
  - bl=0 completes after 1 ack.
  - bl=1023 completes after exactly 1023 acks; s_bry_o mirrors m0_bry_i.
